systolic_array_ws: RTL and testbench

- Second-generation weight-stationary systolic matrix-vector engine: rectangular ROWS x COLS PE grid plus its own scheduler.
- Input skew and output de-skew are internal, so there is no external load_weight/enable_mult sequencing.
- Computes out[c] = sum over r of x[r]*W[r][c] for a stream of input vectors, using valid/ready handshakes on every interface.
- Sits between the activation buffer and the accumulator/activation stage.

---
 rtl/systolic_array_ws.sv | 204 ++++++++++++++++++++
 tb/tb_systolic_array_ws.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_ws.sv
// Weight-stationary ROWS x COLS systolic matrix-vector engine with its own
// weight-load scheduler, input skew, output de-skew and valid/ready handshakes.
module systolic_array_ws #(
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int DATA_SIZE = 16,
   parameter int ACC_SIZE  = 40
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wt_start,
   input  logic                      wt_valid,
   output logic                      wt_ready,
   input  logic [DATA_SIZE*COLS-1:0] wt_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_SIZE*ROWS-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ACC_SIZE*COLS-1:0]  out_sum,
   output logic                      wt_busy
);
   localparam int LAT = ROWS + COLS;
   localparam int CW  = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

   state_t          state_reg;
   logic [CW-1:0]   beat_reg;
   logic            wt_ready_reg;
   logic            wt_busy_reg;
   logic [LAT-1:0]  tok_reg;

   logic stall;
   logic advance;
   logic accept;
   logic wt_fire;
   logic last_beat;

   logic [DATA_SIZE-1:0] x_in    [ROWS];
   logic [DATA_SIZE-1:0] a_left  [ROWS];
   logic [DATA_SIZE-1:0] a_out   [ROWS][COLS];
   logic [ACC_SIZE-1:0]  p_out   [ROWS][COLS];
   logic [ACC_SIZE-1:0]  col_bot [COLS];

   assign out_valid = tok_reg[LAT-1];
   assign stall     = out_valid & ~out_ready;
   assign advance   = ~stall;
   assign in_ready  = (state_reg == COMPUTE) & ~stall;
   assign accept    = in_valid & in_ready;
   assign wt_ready  = wt_ready_reg;
   assign wt_busy   = wt_busy_reg;
   assign wt_fire   = wt_valid & wt_ready_reg;
   assign last_beat = (beat_reg == CW'(ROWS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         beat_reg     <= '0;
         wt_ready_reg <= 1'b0;
         wt_busy_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (wt_start) begin
                  state_reg    <= LOAD;
                  beat_reg     <= '0;
                  wt_ready_reg <= 1'b1;
                  wt_busy_reg  <= 1'b1;
               end
            end
            LOAD: begin
               if (wt_fire) begin
                  if (last_beat) begin
                     state_reg    <= COMPUTE;
                     beat_reg     <= '0;
                     wt_ready_reg <= 1'b0;
                     wt_busy_reg  <= 1'b0;
                  end else begin
                     beat_reg <= beat_reg + 1'b1;
                  end
               end
            end
            COMPUTE: begin
               if (wt_start) begin
                  state_reg   <= DRAIN;
                  wt_busy_reg <= 1'b1;
               end
            end
            DRAIN: begin
               // out_valid is the last token stage, so an empty token line
               // also means nothing is waiting at the output
               if (tok_reg == '0) begin
                  state_reg    <= LOAD;
                  beat_reg     <= '0;
                  wt_ready_reg <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tok_reg <= '0;
      end else if (advance) begin
         tok_reg <= {tok_reg[LAT-2:0], accept};
      end
   end

   genvar gi, gj;

   for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign x_in[gi] = accept ? in_data[gi*DATA_SIZE +: DATA_SIZE] : '0;
      if (gi == 0) begin : g_noskew
         assign a_left[gi] = x_in[gi];
      end else begin : g_skew
         logic [DATA_SIZE-1:0] skew_reg [gi];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < gi; i++) skew_reg[i] <= '0;
            end else if (advance) begin
               skew_reg[0] <= x_in[gi];
               for (int i = 1; i < gi; i++) skew_reg[i] <= skew_reg[i-1];
            end
         end
         assign a_left[gi] = skew_reg[gi-1];
      end
   end

   for (gi = 0; gi < ROWS; gi++) begin : g_pe_row
      for (gj = 0; gj < COLS; gj++) begin : g_pe
         logic [DATA_SIZE-1:0] w_reg;
         logic [DATA_SIZE-1:0] a_reg;
         logic [ACC_SIZE-1:0]  p_reg;
         logic [DATA_SIZE-1:0] a_in;
         logic [ACC_SIZE-1:0]  p_in;
         logic [ACC_SIZE-1:0]  a_ext;
         logic [ACC_SIZE-1:0]  w_ext;

         if (gj == 0) begin : g_a_edge
            assign a_in = a_left[gi];
         end else begin : g_a_chain
            assign a_in = a_out[gi][gj-1];
         end
         if (gi == 0) begin : g_p_top
            assign p_in = '0;
         end else begin : g_p_chain
            assign p_in = p_out[gi-1][gj];
         end

         // full-width product of sign-extended operands wraps modulo 2^ACC_SIZE
         assign a_ext = {{(ACC_SIZE-DATA_SIZE){a_in[DATA_SIZE-1]}}, a_in};
         assign w_ext = {{(ACC_SIZE-DATA_SIZE){w_reg[DATA_SIZE-1]}}, w_reg};

         always_ff @(posedge clk) begin
            if (reset) begin
               w_reg <= '0;
               a_reg <= '0;
               p_reg <= '0;
            end else begin
               if (wt_fire && (beat_reg == CW'(gi)))
                  w_reg <= wt_data[gj*DATA_SIZE +: DATA_SIZE];
               if (advance) begin
                  a_reg <= a_in;
                  p_reg <= p_in + a_ext * w_ext;
               end
            end
         end

         assign a_out[gi][gj] = a_reg;
         assign p_out[gi][gj] = p_reg;
      end
   end

   for (gj = 0; gj < COLS; gj++) begin : g_col
      localparam int DEPTH = COLS - 1 - gj;
      logic [ACC_SIZE-1:0] out_reg;

      if (DEPTH == 0) begin : g_nodesk
         assign col_bot[gj] = p_out[ROWS-1][gj];
      end else begin : g_desk
         logic [ACC_SIZE-1:0] desk_reg [DEPTH];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++) desk_reg[i] <= '0;
            end else if (advance) begin
               desk_reg[0] <= p_out[ROWS-1][gj];
               for (int i = 1; i < DEPTH; i++) desk_reg[i] <= desk_reg[i-1];
            end
         end
         assign col_bot[gj] = desk_reg[DEPTH-1];
      end

      always_ff @(posedge clk) begin
         if (reset) out_reg <= '0;
         else if (advance) out_reg <= col_bot[gj];
      end

      assign out_sum[gj*ACC_SIZE +: ACC_SIZE] = out_reg;
   end

endmodule

// File: tb/tb_systolic_array_ws.sv
// Bench for systolic_array_ws (2x3 grid, 8-bit data, 16-bit sums): directed
// table, multi-cycle corner sequences and a randomized run against a model.
module tb_systolic_array_ws;
   localparam int ROWS = 2;
   localparam int COLS = 3;
   localparam int DS   = 8;
   localparam int AS   = 16;
   localparam int LAT  = ROWS + COLS;

   logic                 clk       = 1'b0;
   logic                 reset     = 1'b1;
   logic                 wt_start  = 1'b0;
   logic                 wt_valid  = 1'b0;
   logic                 wt_ready;
   logic [DS*COLS-1:0]   wt_data   = '0;
   logic                 in_valid  = 1'b0;
   logic                 in_ready;
   logic [DS*ROWS-1:0]   in_data   = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic [AS*COLS-1:0]   out_sum;
   logic                 wt_busy;

   systolic_array_ws #(.ROWS(ROWS), .COLS(COLS), .DATA_SIZE(DS), .ACC_SIZE(AS)) dut (
      .clk(clk), .reset(reset),
      .wt_start(wt_start), .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .wt_busy(wt_busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_acc = 0;
   bit lat_check = 1'b0;

   logic signed [DS-1:0] wm [ROWS][COLS];
   int                   wbeat = 0;
   logic [AS*COLS-1:0]   expq [$];
   int                   accq [$];
   logic [AS*COLS-1:0]   got  [$];

   typedef struct {
      logic [DS*ROWS-1:0] x;
      logic [AS*COLS-1:0] exp;
   } vec_t;
   vec_t tbl [6];
   logic [DS*ROWS-1:0] bp_vec [6];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic fail_line(input string name);
      total++;
      bad++;
      $display("FAIL %s", name);
   endtask

   // out[c] = sum_r x[r]*W[r][c], truncated to AS bits
   function automatic logic [AS*COLS-1:0] model(input logic [DS*ROWS-1:0] x);
      logic [AS*COLS-1:0] r;
      longint s;
      r = '0;
      for (int c = 0; c < COLS; c++) begin
         s = 0;
         for (int k = 0; k < ROWS; k++)
            s += longint'($signed(x[k*DS +: DS])) * longint'(wm[k][c]);
         r[c*AS +: AS] = s[AS-1:0];
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         expq.delete();
         accq.delete();
         wbeat = 0;
         for (int k = 0; k < ROWS; k++)
            for (int c = 0; c < COLS; c++) wm[k][c] = '0;
      end else begin
         if (out_valid) begin
            if (expq.size() == 0) begin
               fail_line("out_valid_without_pending_vector");
            end else begin
               check("out_sum", 64'(out_sum), 64'(expq[0]));
               if (out_ready) begin
                  if (lat_check) check("latency", 64'(cyc - accq[0]), 64'(LAT));
                  got.push_back(out_sum);
                  void'(expq.pop_front());
                  void'(accq.pop_front());
               end else begin
                  check("in_ready_in_stall", 64'(in_ready), 64'(0));
               end
            end
         end
         if (in_valid && in_ready) begin
            expq.push_back(model(in_data));
            accq.push_back(cyc);
            n_acc++;
         end
         if (wt_valid && wt_ready) begin
            for (int c = 0; c < COLS; c++) wm[wbeat][c] = wt_data[c*DS +: DS];
            wbeat = (wbeat + 1) % ROWS;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_wt_ready();
      int n = 0;
      while (!wt_ready && n < 60) begin
         tick();
         n++;
      end
      if (!wt_ready) fail_line("wt_ready_timeout");
   endtask

   task automatic wait_empty();
      int n = 0;
      while (expq.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      check("drain_pending", 64'(expq.size()), 64'(0));
   endtask

   task automatic load_w(input logic [DS*COLS*ROWS-1:0] wflat, input int gap, input bit start);
      if (start) begin
         wt_start = 1'b1;
         tick();
         wt_start = 1'b0;
      end
      wait_wt_ready();
      check("load_busy", 64'(wt_busy), 64'(1));
      for (int k = 0; k < ROWS; k++) begin
         for (int g = 0; g < gap; g++) begin
            check("gap_wt_ready", 64'(wt_ready), 64'(1));
            check("gap_in_ready", 64'(in_ready), 64'(0));
            tick();
         end
         wt_valid = 1'b1;
         wt_data  = wflat[k*DS*COLS +: DS*COLS];
         tick();
         wt_valid = 1'b0;
      end
      check("load_done_wt_ready", 64'(wt_ready), 64'(0));
      check("load_done_in_ready", 64'(in_ready), 64'(1));
      check("load_done_busy", 64'(wt_busy), 64'(0));
   endtask

   localparam logic [DS*COLS*ROWS-1:0] W1 = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
   localparam logic [DS*COLS*ROWS-1:0] W2 = {8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0};
   localparam logic [DS*COLS*ROWS-1:0] WN = {8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};

   initial begin
      int base;
      tbl[0] = '{16'h0101, {16'd9, 16'd7, 16'd5}};
      tbl[1] = '{16'hFF02, {16'h0000, 16'hFFFF, 16'hFFFE}};
      tbl[2] = '{16'h0000, 48'h0};
      tbl[3] = '{16'h7F80, {16'd378, 16'd379, 16'd380}};
      tbl[4] = '{16'h7F7F, {16'd1143, 16'd889, 16'd635}};
      tbl[5] = '{16'hFE03, {16'hFFFD, 16'hFFFC, 16'hFFFB}};

      tick();
      tick();
      reset = 1'b0;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_sum", 64'(out_sum), 64'(0));
      check("rst_wt_ready", 64'(wt_ready), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_wt_busy", 64'(wt_busy), 64'(0));

      load_w(W1, 0, 1'b1);

      lat_check = 1'b1;
      got.delete();
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = tbl[i].x;
         tick();
      end
      in_valid = 1'b0;
      wait_empty();
      lat_check = 1'b0;
      check("table_count", 64'(got.size()), 64'(6));
      for (int i = 0; i < got.size() && i < 6; i++)
         check($sformatf("table_%0d", i), 64'(got[i]), 64'(tbl[i].exp));

      // six vectors with four stalled cycles starting at the first result
      for (int k = 0; k < 6; k++) bp_vec[k] = 16'($urandom);
      got.delete();
      base = n_acc;
      for (int i = 0; i < 40; i++) begin
         out_ready = !(i >= 5 && i < 9);
         in_valid  = (n_acc - base) < 6;
         if (in_valid) in_data = bp_vec[n_acc - base];
         if (i == 7) begin
            #1;
            check("bp_out_valid_held", 64'(out_valid), 64'(1));
            check("bp_in_ready_low", 64'(in_ready), 64'(0));
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_empty();
      check("bp_count", 64'(got.size()), 64'(6));
      for (int k = 0; k < got.size() && k < 6; k++)
         check($sformatf("bp_%0d", k), 64'(got[k]), 64'(model(bp_vec[k])));

      // reload requested alongside the third in-flight vector
      got.delete();
      in_valid = 1'b1;
      in_data  = 16'h0001;
      tick();
      in_data  = 16'h0100;
      tick();
      in_data  = 16'h0101;
      wt_start = 1'b1;
      tick();
      in_valid = 1'b0;
      wt_start = 1'b0;
      check("reload_busy", 64'(wt_busy), 64'(1));
      check("reload_in_ready", 64'(in_ready), 64'(0));
      load_w(W2, 0, 1'b0);
      check("reload_old_count", 64'(got.size()), 64'(3));
      if (got.size() >= 3) begin
         check("reload_old_0", 64'(got[0]), 64'({16'd3, 16'd2, 16'd1}));
         check("reload_old_1", 64'(got[1]), 64'({16'd6, 16'd5, 16'd4}));
         check("reload_old_2", 64'(got[2]), 64'({16'd9, 16'd7, 16'd5}));
      end
      in_valid = 1'b1;
      in_data  = {8'd9, 8'd7};
      tick();
      in_valid = 1'b0;
      wait_empty();
      if (got.size() >= 4) check("reload_new", 64'(got[3]), 64'({16'd7, 16'd0, 16'd9}));
      else fail_line("reload_new_missing");

      // 2 * (-128 * -128) = 32768 wraps to 0x8000
      load_w(WN, 0, 1'b1);
      got.delete();
      in_valid = 1'b1;
      in_data  = 16'h8080;
      tick();
      in_valid = 1'b0;
      wait_empty();
      if (got.size() >= 1) check("overflow_wrap", 64'(got[0]), 64'(48'h8000_8000_8000));
      else fail_line("overflow_missing");

      // reset with two vectors in flight
      in_valid = 1'b1;
      in_data  = 16'h0101;
      tick();
      tick();
      in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_wt_ready", 64'(wt_ready), 64'(0));
      check("midrst_in_ready", 64'(in_ready), 64'(0));
      check("midrst_wt_busy", 64'(wt_busy), 64'(0));
      base = n_acc;
      in_valid = 1'b1;
      in_data  = 16'h0101;
      for (int i = 0; i < 10; i++) tick();
      in_valid = 1'b0;
      check("midrst_no_accept", 64'(n_acc - base), 64'(0));
      check("midrst_still_no_out", 64'(out_valid), 64'(0));

      // beats spaced three cycles apart
      load_w(W1, 3, 1'b1);
      got.delete();
      in_valid = 1'b1;
      in_data  = 16'hFF02;
      tick();
      in_valid = 1'b0;
      wait_empty();
      if (got.size() >= 1) check("gap_result", 64'(got[0]), 64'({16'h0000, 16'hFFFF, 16'hFFFE}));
      else fail_line("gap_result_missing");

      // randomized traffic under two random weight sets
      for (int round = 0; round < 2; round++) begin
         load_w(48'({$urandom, $urandom}), 0, 1'b1);
         base = n_acc;
         for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         wait_empty();
         if (n_acc - base < 50) fail_line("random_too_few_accepts");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

endmodule
